lc4_regfile_nzp: RTL
====================

Name: lc4_regfile_nzp

Overview:
- Architectural register file for the LC4 datapath, directly upstream of the ALU.
- Supplies the i_r1data and i_r2data operands to the ALU, and captures the ALU/writeback result at the end of the cycle.
- Also holds the NZP condition-code register, updated from the written value, which branch logic consumes.
- Optional write-to-read bypass so a single-cycle datapath sees same-cycle writes when configured.

Parameters:
n, 16, data width of each register and of the write/read data ports
BYPASS, 0, 1 = read ports forward same-cycle write data; 0 = reads return stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
gwe  input  1  global write enable; when 0 no state changes (single-step/stall)
i_rs  input  3  read port 1 register index
o_rs_data  output  n  read port 1 data (to ALU i_r1data)
i_rt  input  3  read port 2 register index
o_rt_data  output  n  read port 2 data (to ALU i_r2data)
i_rd  input  3  write register index
i_wdata  input  n  write data (ALU result / load data / PC+1)
i_rd_we  input  1  register write enable
i_nzp_we  input  1  NZP update enable
o_nzp  output  3  current NZP bits {N,Z,P}

Behaviour:
- Clock is clk. Reset is synchronous and active-high: rst sampled at the rising edge of clk.
- Storage: 8 registers R0..R7, each n bits. R0 is an ordinary writable register; there is no hardwired zero.
- Reset: on an edge with rst=1, all R0..R7 become 0 and the NZP register becomes 3'b000. Reset wins over gwe and all write enables in the same cycle. With all registers 0, o_rs_data, o_rt_data and o_nzp all read 0 the cycle after reset.
- Register write: at an edge with rst=0, gwe=1 and i_rd_we=1, R[i_rd] <= i_wdata. Otherwise R[i_rd] holds.
- NZP write: at an edge with rst=0, gwe=1 and i_nzp_we=1, NZP is loaded as follows:
  - 3'b100 if i_wdata[n-1]=1;
  - 3'b010 if i_wdata==0;
  - 3'b001 otherwise.
- i_nzp_we is independent of i_rd_we. NZP may update without a register write (e.g. CMP), and a register may be written without an NZP update.
- gwe=0: registers and NZP hold regardless of i_rd_we and i_nzp_we.
- Reads are combinational, with zero latency from i_rs/i_rt to o_rs_data/o_rt_data.
- BYPASS=0: a read returns the pre-edge value even if the same index is written this cycle. The new value is visible the cycle after the edge.
- BYPASS=1: if gwe & i_rd_we & (i_rd==i_rs), o_rs_data = i_wdata. The same rule applies independently to i_rt/o_rt_data.
- BYPASS=1 and o_nzp: o_nzp is also forwarded when gwe & i_nzp_we, showing the value that will be loaded. It is otherwise the stored value.
- Both read ports may address the same register, including the one being written. Both then return identical data.
- o_nzp is always one-hot except the reset value 3'b000.
- Width rule: the sign is taken from bit n-1 of i_wdata; no extension or truncation.
- No X propagation: every output is defined after the first reset edge.

Decomposition:
- Shared package/header (lc4 constants) holds:
  - NZP encodings: NZP_N=3'b100, NZP_Z=3'b010, NZP_P=3'b001, NZP_RESET=3'b000;
  - register count 8 and index width 3.
- One sub-module: lc4_reg. It is a parameterised n-bit register with clk, rst, we and reset value, instantiated 8 times for R0..R7 and once (width 3) for NZP.
- Read muxes and bypass logic stay in lc4_regfile_nzp.

Test Plan:
- Reset: hold rst=1 for 2 edges with i_rd_we=i_nzp_we=gwe=1 and i_wdata=16'hFFFF -> all 8 registers read 0 via both ports, and o_nzp=3'b000.
- Write/readback: gwe=1, write R3=16'h1234 and R7=16'h8000 on consecutive edges -> i_rs=3 gives 16'h1234, i_rt=7 gives 16'h8000, and R0..R2, R4..R6 still 0.
- NZP encoding: i_nzp_we=1, i_rd_we=0, with i_wdata 16'hFFFE, 16'h0000, 16'h0001 on successive edges -> o_nzp goes 100, 010, 001, and no register changes.
- gwe stall: gwe=0, i_rd_we=1, i_nzp_we=1, i_rd=2, i_wdata=16'hBEEF -> R2 unchanged and o_nzp unchanged; with gwe=1 the next edge writes R2=16'hBEEF.
- Bypass: i_rs=i_rt=i_rd=5, i_wdata=16'h00AA, i_rd_we=1, gwe=1 before the edge:
  - BYPASS=1: both outputs read 16'h00AA pre-edge;
  - BYPASS=0: both outputs read the old R5 pre-edge and 16'h00AA post-edge.
- Reset mid-operation: rst=1 on the same edge as a write of R4=16'h7777 with i_nzp_we=1 -> R4=0 and o_nzp=3'b000 after the edge.

Source files
------------

// File: rtl/lc4_regfile_nzp_pkg.sv
// Shared LC4 register-file constants: NZP encodings and register-array geometry.
package lc4_regfile_nzp_pkg;

  localparam int NZP_W     = 3;
  localparam int REG_COUNT = 8;
  localparam int REG_IDX_W = 3;

  typedef logic [NZP_W-1:0]     nzpT;
  typedef logic [REG_IDX_W-1:0] regIdxT;

  // Condition codes are one-hot {N,Z,P}; all-zero only appears out of reset.
  localparam nzpT NZP_N     = 3'b100;
  localparam nzpT NZP_Z     = 3'b010;
  localparam nzpT NZP_P     = 3'b001;
  localparam nzpT NZP_RESET = 3'b000;

endpackage

// File: rtl/lc4_reg.sv
// Generic n-bit state register with synchronous active-high reset and load enable.
module lc4_reg #(
  parameter int           n         = 16,
  parameter logic [n-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/lc4_regfile_nzp.sv
// LC4 architectural register file (R0..R7) with NZP condition-code register and optional write-to-read bypass.
module lc4_regfile_nzp
  import lc4_regfile_nzp_pkg::*;
#(
  parameter int n      = 16,
  parameter bit BYPASS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic [2:0]   i_rs,
  output logic [n-1:0] o_rs_data,
  input  logic [2:0]   i_rt,
  output logic [n-1:0] o_rt_data,
  input  logic [2:0]   i_rd,
  input  logic [n-1:0] i_wdata,
  input  logic         i_rd_we,
  input  logic         i_nzp_we,
  output logic [2:0]   o_nzp
);

  logic [n-1:0]         regQ [REG_COUNT];
  logic [REG_COUNT-1:0] regWe;
  nzpT                  nzpQ;
  nzpT                  nzpNext;
  logic                 rdWrite;
  logic                 nzpWrite;

  // Sign comes straight from the top bit of the written value; no extension.
  function automatic nzpT nzpEncode(input logic [n-1:0] w);
    if (w[n-1]) begin
      return NZP_N;
    end else if (w == '0) begin
      return NZP_Z;
    end else begin
      return NZP_P;
    end
  endfunction

  assign rdWrite  = gwe & i_rd_we;
  assign nzpWrite = gwe & i_nzp_we;
  assign nzpNext  = nzpEncode(i_wdata);

  for (genvar g = 0; g < REG_COUNT; g++) begin : genRegs
    assign regWe[g] = rdWrite && (i_rd == regIdxT'(g));

    lc4_reg #(
      .n         (n),
      .RESET_VAL ({n{1'b0}})
    ) uReg (
      .clk (clk),
      .rst (rst),
      .we  (regWe[g]),
      .d   (i_wdata),
      .q   (regQ[g])
    );
  end

  lc4_reg #(
    .n         (NZP_W),
    .RESET_VAL (NZP_RESET)
  ) uNzp (
    .clk (clk),
    .rst (rst),
    .we  (nzpWrite),
    .d   (nzpNext),
    .q   (nzpQ)
  );

  // Forwarding only exists when BYPASS is set; otherwise reads see pre-edge state.
  always_comb begin
    o_rs_data = regQ[i_rs];
    o_rt_data = regQ[i_rt];
    o_nzp     = nzpQ;
    if (BYPASS && rdWrite && (i_rd == i_rs)) begin
      o_rs_data = i_wdata;
    end
    if (BYPASS && rdWrite && (i_rd == i_rt)) begin
      o_rt_data = i_wdata;
    end
    if (BYPASS && nzpWrite) begin
      o_nzp = nzpNext;
    end
  end

endmodule
